seq_det_window_counter: RTL and testbench
=========================================

Name: seq_det_window_counter

Overview:
- Downstream consumer of the 1-bit detection output of the 101/110 sequence detectors.
- Counts detection pulses over fixed windows of WINDOW enabled clock cycles and reports each window's total through a valid/ready interface.
- Provides saturation, a window sequence number, and a sticky overrun flag so a slow reader cannot silently lose windows.

Parameters:
- WINDOW, 16, enabled cycles per window; legal range is 2 or more.
- CNT_W, 5, width of the event count; the count saturates at 2^CNT_W-1.
- SEQ_W, 4, width of the window sequence number; wraps modulo 2^SEQ_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  qualifies the cycle; when low, window position and count freeze.
- det_in  input  1  detector output; sampled at posedge clk, each high cycle counts as one event.
- clr  input  1  synchronous clear of window position, event count and overrun.
- rpt_count  output  CNT_W  event total of the reported window.
- rpt_seq  output  SEQ_W  sequence number of the reported window.
- rpt_valid  output  1  report held and available.
- rpt_ready  input  1  consumer accepts the report.
- overrun  output  1  sticky; a closed window was dropped because the previous report was not accepted.

Behaviour:
- Reset (async, rst=1): window position=0, event count=0, seq counter=0, rpt_count=0, rpt_seq=0, rpt_valid=0, overrun=0.
- Internal state: pos (0..WINDOW-1), cnt (CNT_W bits, saturating), seq (SEQ_W bits).
- Enabled cycle (en=1, clr=0), pos<WINDOW-1: pos+1; cnt=sat(cnt+det_in).
- Closing cycle (en=1, clr=0, pos==WINDOW-1):
  - Window total = sat(cnt+det_in). A det_in high on the last cycle belongs to the closing window.
  - pos and cnt return to 0; seq increments (wraps).
  - If the report slot is free, load rpt_count=total, rpt_seq=seq, rpt_valid=1 on that edge. The slot is free when rpt_valid=0, or rpt_valid=1 and rpt_ready=1 on the same edge.
  - If the slot is not free: keep the held report unchanged, discard the new total, set overrun=1. seq still increments, so dropped windows appear as gaps in rpt_seq.
- en=0: pos, cnt and seq hold; det_in is ignored. The report handshake still operates.
- Handshake: a transfer occurs at a posedge with rpt_valid=1 and rpt_ready=1.
  - After a transfer, rpt_valid=0 next cycle unless a window closes on the same edge, in which case the new report loads with no bubble and no overrun.
  - rpt_count and rpt_seq are stable while rpt_valid=1 and not accepted.
  - rpt_ready while rpt_valid=0 has no effect.
- Latency: rpt_valid rises on the same edge as the closing cycle (registered), i.e. visible in the cycle after the last window bit.
- clr=1 (priority over en and window close):
  - pos=0, cnt=0, overrun=0; a closing window on that edge is discarded with no report and no seq increment.
  - seq, rpt_* and any pending report are untouched; a handshake on the same edge still completes.
- Saturation: cnt and total never wrap; they hold at 2^CNT_W-1.
- Async rst mid-window or with a pending report: all state clears immediately; a pending report is lost.

Test Plan:
- Basic count: WINDOW=16, en=1, rpt_ready=1, det_in high on window cycles 2, 7 and 15 (the last) -> rpt_valid pulses 1 cycle after cycle 15, rpt_count=3, rpt_seq=0; next window with no pulses -> rpt_count=0, rpt_seq=1.
- Enable gating: en low for 5 cycles mid-window with det_in=1 throughout -> those cycles not counted; window closes 5 cycles later than ungated; rpt_count excludes them.
- Backpressure/overrun: rpt_ready=0 for 3 full windows with totals 2, 4 and 1 -> rpt_count stays 2, rpt_seq stays 0, overrun=1 from the end of window 1; raise rpt_ready -> one transfer of (2, 0); the next window reports rpt_seq=3.
- Back-to-back accept: rpt_ready=1 exactly on a window-close edge while the previous report is pending -> old report transferred, new one loaded on the same edge, rpt_valid stays 1, overrun=0.
- Saturation: CNT_W=3, WINDOW=16, det_in=1 every cycle -> rpt_count=7.
- Clear and reset: clr at pos==WINDOW-1 -> no report, seq unchanged, overrun=0; rst asserted mid-window with rpt_valid=1 -> all outputs 0 immediately without waiting for a clock edge; counting restarts at pos 0 after release.

Source files
------------

// File: rtl/seq_det_window_counter.sv
// Counts detector pulses over windows of WINDOW enabled cycles and reports each window total.
// Latency: the report is registered on the window's closing edge and visible the next cycle.
// Backpressure: one report slot; a window closing on an unaccepted report is dropped and sets a sticky overrun flag.
module seq_det_window_counter #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 5,
    parameter int SEQ_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             det_in,
    input  logic             clr,
    output logic [CNT_W-1:0] rpt_count,
    output logic [SEQ_W-1:0] rpt_seq,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic             overrun
);

    localparam int                PW       = $clog2(WINDOW);
    localparam logic [PW-1:0]     LAST_POS = PW'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PW-1:0]    pos;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [SEQ_W-1:0] seq;
    logic             closing;
    logic             slot_free;

    // A pulse on the closing cycle still belongs to the window being closed.
    always_comb begin
        cnt_next = cnt;
        if (det_in && (cnt != CNT_MAX)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    assign closing   = en && !clr && (pos == LAST_POS);
    assign slot_free = !rpt_valid || rpt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
            cnt <= '0;
            seq <= '0;
        end else if (clr) begin
            pos <= '0;
            cnt <= '0;
        end else if (en) begin
            if (pos == LAST_POS) begin
                pos <= '0;
                cnt <= '0;
                seq <= seq + 1'b1;
            end else begin
                pos <= pos + 1'b1;
                cnt <= cnt_next;
            end
        end
    end

    // Accepting the old report and loading a new one can share an edge, so no bubble appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_count <= '0;
            rpt_seq   <= '0;
            rpt_valid <= 1'b0;
        end else if (closing && slot_free) begin
            rpt_count <= cnt_next;
            rpt_seq   <= seq;
            rpt_valid <= 1'b1;
        end else if (rpt_valid && rpt_ready) begin
            rpt_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (clr) begin
            overrun <= 1'b0;
        end else if (closing && !slot_free) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_det_window_counter.sv
module tb_seq_det_window_counter;

    localparam int WINDOW = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, det_in, clr, rpt_ready;
    logic [4:0] rpt_count;
    logic [3:0] rpt_seq;
    logic       rpt_valid, overrun;
    logic [2:0] s_count;
    logic [3:0] s_seq;
    logic       s_valid, s_overrun;

    int errors = 0;
    int checks = 0;

    // Reference state: window position, unsaturated event count, report slot.
    int m_pos, m_ev, m_seq, m_total, m_rseq;
    bit m_valid, m_ovr;

    seq_det_window_counter #(.WINDOW(WINDOW), .CNT_W(5), .SEQ_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .det_in(det_in), .clr(clr),
        .rpt_count(rpt_count), .rpt_seq(rpt_seq), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .overrun(overrun)
    );

    seq_det_window_counter #(.WINDOW(WINDOW), .CNT_W(3), .SEQ_W(4)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .det_in(det_in), .clr(clr),
        .rpt_count(s_count), .rpt_seq(s_seq), .rpt_valid(s_valid),
        .rpt_ready(rpt_ready), .overrun(s_overrun)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_ev = 0; m_seq = 0; m_total = 0; m_rseq = 0;
        m_valid = 0; m_ovr = 0;
    endtask

    task automatic model_step(input bit e, input bit d, input bit c, input bit r);
        int  tot;
        bit  close;
        close = e && !c && (m_pos == WINDOW - 1);
        tot   = m_ev + int'(d);
        if (close) begin
            if (!m_valid || r) begin
                m_total = tot;
                m_rseq  = m_seq;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
            m_seq = (m_seq + 1) % 16;
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        if (c) begin
            m_pos = 0; m_ev = 0; m_ovr = 0;
        end else if (e) begin
            if (close) begin
                m_pos = 0; m_ev = 0;
            end else begin
                m_pos = m_pos + 1; m_ev = tot;
            end
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".valid"},    32'(rpt_valid), 32'(m_valid));
        chk({where, ".count"},    32'(rpt_count), 32'(sat(m_total, 31)));
        chk({where, ".seq"},      32'(rpt_seq),   32'(m_rseq));
        chk({where, ".overrun"},  32'(overrun),   32'(m_ovr));
        chk({where, ".count_c3"}, 32'(s_count),   32'(sat(m_total, 7)));
        chk({where, ".valid_c3"}, 32'(s_valid),   32'(m_valid));
    endtask

    task automatic step(input string where, input bit e, input bit d, input bit c, input bit r);
        en = e; det_in = d; clr = c; rpt_ready = r;
        model_step(e, d, c, r);
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    // Asserts reset between clock edges and checks outputs clear with no edge.
    task automatic async_reset(input string where);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk({where, ".rst_valid"},   32'(rpt_valid), 32'd0);
        chk({where, ".rst_count"},   32'(rpt_count), 32'd0);
        chk({where, ".rst_seq"},     32'(rpt_seq),   32'd0);
        chk({where, ".rst_overrun"}, 32'(overrun),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        check_all({where, ".post_rst"});
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; det_in = 1'b0; clr = 1'b0; rpt_ready = 1'b0;
        model_reset();
        #1;
        async_reset("init");

        // Basic count: pulses at positions 2, 7 and 15 of window 0.
        for (int i = 0; i < WINDOW; i++)
            step("basic", 1'b1, (i == 2) || (i == 7) || (i == 15), 1'b0, 1'b1);
        chk("basic.valid_after_close", 32'(rpt_valid), 32'd1);
        chk("basic.count_3", 32'(rpt_count), 32'd3);
        chk("basic.seq_0", 32'(rpt_seq), 32'd0);
        step("basic_empty", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("basic.valid_drops", 32'(rpt_valid), 32'd0);
        for (int i = 1; i < WINDOW; i++)
            step("basic_empty", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("basic.empty_count", 32'(rpt_count), 32'd0);
        chk("basic.empty_seq", 32'(rpt_seq), 32'd1);

        // Enable gating: five disabled cycles with det_in high do not count.
        for (int i = 0; i < WINDOW + 5; i++) begin
            step("gate", !((i >= 6) && (i < 11)), 1'b1, 1'b0, 1'b1);
            if (i == WINDOW - 1) chk("gate.not_closed_early", 32'(rpt_valid), 32'd0);
        end
        chk("gate.count_16", 32'(rpt_count), 32'd16);
        chk("gate.sat_count_7", 32'(s_count), 32'd7);
        chk("gate.seq_2", 32'(rpt_seq), 32'd2);

        // Backpressure: three windows with totals 2, 4, 1 and no reader.
        async_reset("bp");
        for (int w = 0; w < 3; w++) begin
            int tot;
            tot = (w == 0) ? 2 : (w == 1) ? 4 : 1;
            for (int i = 0; i < WINDOW; i++)
                step("bp", 1'b1, i < tot, 1'b0, 1'b0);
            chk("bp.held_count", 32'(rpt_count), 32'd2);
            chk("bp.held_seq", 32'(rpt_seq), 32'd0);
            chk("bp.overrun", 32'(overrun), (w == 0) ? 32'd0 : 32'd1);
        end
        step("bp_accept", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp.valid_after_accept", 32'(rpt_valid), 32'd0);
        for (int i = 0; i < WINDOW; i++)
            step("bp_next", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("bp.gap_seq_3", 32'(rpt_seq), 32'd3);
        chk("bp.overrun_sticky", 32'(overrun), 32'd1);

        // Back-to-back: accept exactly on the close edge of the next window.
        step("b2b_clr", 1'b1, 1'b0, 1'b1, 1'b1);
        chk("b2b.clr_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < WINDOW; i++)
            step("b2b_a", 1'b1, i < 5, 1'b0, 1'b0);
        for (int i = 0; i < WINDOW; i++)
            step("b2b_b", 1'b1, i >= 13, 1'b0, i == WINDOW - 1);
        chk("b2b.valid_held", 32'(rpt_valid), 32'd1);
        chk("b2b.new_count", 32'(rpt_count), 32'd3);
        chk("b2b.new_seq", 32'(rpt_seq), 32'd5);
        chk("b2b.no_overrun", 32'(overrun), 32'd0);

        // Clear on the closing cycle discards the window without a seq step.
        for (int i = 0; i < WINDOW - 1; i++)
            step("clr_last", 1'b1, 1'b1, 1'b0, 1'b1);
        step("clr_last_edge", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr.no_report", 32'(rpt_valid), 32'd0);
        for (int i = 0; i < WINDOW; i++)
            step("clr_next", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr.seq_unchanged", 32'(rpt_seq), 32'd6);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++)
            step("rand", $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0);

        // Async reset with a pending report, mid-window.
        for (int i = 0; i < WINDOW + 4; i++)
            step("rst_pend", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst.pending_before", 32'(rpt_valid), 32'd1);
        async_reset("midrst");
        for (int i = 0; i < WINDOW; i++) begin
            step("restart", 1'b1, 1'b1, 1'b0, 1'b0);
            if (i == WINDOW - 2) chk("restart.not_yet", 32'(rpt_valid), 32'd0);
        end
        chk("restart.valid", 32'(rpt_valid), 32'd1);
        chk("restart.count_16", 32'(rpt_count), 32'd16);
        chk("restart.seq_0", 32'(rpt_seq), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
